fetch_align_buffer: RTL and testbench

- Halfword-granular instruction queue between the I-cache fetch output and the IFID register of the dual-issue core.
- Accepts 64-bit fetch packets and realigns mixed 16/32-bit RVC/RV32 instructions into two decode slots (slot0 older, slot1 younger), each with its own PC and a 16-bit flag.
- Decode can then consume 0, 1 or 2 instructions per cycle.
- Replaces the fixed two-word IFID assumption.

---
 rtl/fetch_align_buffer_pkg.sv | 23 ++
 rtl/fb_slot_decode.sv | 37 +++
 rtl/fetch_align_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_align_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_buffer_pkg.sv
// Shared constants, types and helpers for the halfword-granular fetch align buffer.
// Imported by the buffer top and its slot decoder.
package fetch_align_buffer_pkg;

    localparam int          FB_DEPTH_HW = 16;
    localparam int          HW_WIDTH    = 16;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef logic [HW_WIDTH-1:0] halfword_t;

    typedef enum logic [1:0] {
        TAKE_NONE = 2'd0,
        TAKE_ONE  = 2'd1,
        TAKE_TWO  = 2'd2,
        TAKE_BAD  = 2'd3
    } take_e;

    // A halfword opens a compressed instruction unless its two low bits are both set.
    function automatic logic is_rvc(input halfword_t h);
        return (h[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fb_slot_decode.sv
// Length and instruction extraction for one decode slot, given the halfwords at
// its start and the number of halfwords already claimed by older slots.
module fb_slot_decode
    import fetch_align_buffer_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          prev_valid,
    input  logic [CW-1:0] base_hw,
    input  logic [CW-1:0] count,
    input  halfword_t     hw_lo,
    input  halfword_t     hw_hi,
    output logic          valid,
    output logic [31:0]   instr,
    output logic          is16,
    output logic [1:0]    len
);

    logic          rvc_s;
    logic [CW-1:0] need_s;

    // Slot is complete only when every halfword it spans is already queued.
    always_comb begin
        rvc_s  = is_rvc(hw_lo);
        len    = rvc_s ? 2'd1 : 2'd2;
        need_s = base_hw + CW'(len);
        valid  = prev_valid & (count >= need_s);
        if (valid) begin
            instr = rvc_s ? {16'h0000, hw_lo} : {hw_hi, hw_lo};
            is16  = rvc_s;
        end else begin
            instr = NOP;
            is16  = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Halfword instruction queue realigning 64-bit fetch packets into two decode
// slots of mixed 16/32-bit instructions; decode pops 0, 1 or 2 per cycle.
module fetch_align_buffer
    import fetch_align_buffer_pkg::*;
#(
    parameter int          DEPTH_HW = FB_DEPTH_HW,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_data,
    input  logic [31:0]               in_pc,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    output logic                      slot0_valid,
    output logic [31:0]               slot0_instr,
    output logic [31:0]               slot0_pc,
    output logic                      slot0_is16,
    output logic                      slot1_valid,
    output logic [31:0]               slot1_instr,
    output logic [31:0]               slot1_pc,
    output logic                      slot1_is16,
    input  logic [1:0]                take,
    output logic [$clog2(DEPTH_HW):0] count
);

    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = PW + 1;

    halfword_t     mem_r [DEPTH_HW];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   head_pc_r;

    logic [CW-1:0] free_s;
    logic          in_ready_s;
    logic [1:0]    off_s;
    logic [2:0]    n_push_s;
    logic [2:0]    push_n_eff_s;
    logic          push_fire_s;
    logic [PW-1:0] wr_idx_s [4];
    logic [3:0]    wr_en_s;

    logic [PW-1:0] rd_p1_s;
    logic [PW-1:0] rd_p2_s;
    logic [PW-1:0] rd_p3_s;
    halfword_t     h0_s;
    halfword_t     h1_s;
    halfword_t     h2_s;
    halfword_t     h3_s;
    halfword_t     s1_lo_s;
    halfword_t     s1_hi_s;

    logic          s0_valid_s;
    logic          s1_valid_s;
    logic [31:0]   s0_instr_s;
    logic [31:0]   s1_instr_s;
    logic          s0_is16_s;
    logic          s1_is16_s;
    logic [1:0]    len0_s;
    logic [1:0]    len1_s;

    take_e         take_s;
    logic [2:0]    n_pop_s;
    logic          unused_pc_bits_s;

    // Only the halfword offset of the packet address matters to the queue.
    assign unused_pc_bits_s = ^{in_pc[31:3], in_pc[0]};

    // Push acceptance uses the registered count only, so a same-cycle pop never frees room.
    always_comb begin
        free_s       = CW'(DEPTH_HW) - count_r;
        in_ready_s   = (free_s >= CW'(4));
        off_s        = in_pc[2:1];
        n_push_s     = 3'd4 - {1'b0, off_s};
        push_fire_s  = in_valid & in_ready_s & ~flush;
        push_n_eff_s = push_fire_s ? n_push_s : 3'd0;
        for (int k = 0; k < 4; k++) begin
            wr_idx_s[k] = wr_ptr_r + PW'(k) - PW'(off_s);
            wr_en_s[k]  = push_fire_s & (2'(k) >= off_s);
        end
    end

    // Four halfwords from the head cover both slots in every length combination.
    always_comb begin
        rd_p1_s = rd_ptr_r + PW'(1);
        rd_p2_s = rd_ptr_r + PW'(2);
        rd_p3_s = rd_ptr_r + PW'(3);
        h0_s    = mem_r[rd_ptr_r];
        h1_s    = mem_r[rd_p1_s];
        h2_s    = mem_r[rd_p2_s];
        h3_s    = mem_r[rd_p3_s];
    end

    // Slot1 begins right after slot0, whose length is known from h0 alone.
    always_comb begin
        if (len0_s == 2'd1) begin
            s1_lo_s = h1_s;
            s1_hi_s = h2_s;
        end else begin
            s1_lo_s = h2_s;
            s1_hi_s = h3_s;
        end
    end

    fb_slot_decode #(.CW(CW)) u_slot0 (
        .prev_valid (1'b1),
        .base_hw    ({CW{1'b0}}),
        .count      (count_r),
        .hw_lo      (h0_s),
        .hw_hi      (h1_s),
        .valid      (s0_valid_s),
        .instr      (s0_instr_s),
        .is16       (s0_is16_s),
        .len        (len0_s)
    );

    fb_slot_decode #(.CW(CW)) u_slot1 (
        .prev_valid (s0_valid_s),
        .base_hw    (CW'(len0_s)),
        .count      (count_r),
        .hw_lo      (s1_lo_s),
        .hw_hi      (s1_hi_s),
        .valid      (s1_valid_s),
        .instr      (s1_instr_s),
        .is16       (s1_is16_s),
        .len        (len1_s)
    );

    // Pop size in halfwords; over-asking (including take=3) pops only the valid slots.
    always_comb begin
        take_s  = take_e'(take);
        n_pop_s = 3'd0;
        case (take_s)
            TAKE_NONE: n_pop_s = 3'd0;
            TAKE_ONE: begin
                if (s0_valid_s) begin
                    n_pop_s = {1'b0, len0_s};
                end else begin
                    n_pop_s = 3'd0;
                end
            end
            TAKE_TWO, TAKE_BAD: begin
                if (s1_valid_s) begin
                    n_pop_s = {1'b0, len0_s} + {1'b0, len1_s};
                end else if (s0_valid_s) begin
                    n_pop_s = {1'b0, len0_s};
                end else begin
                    n_pop_s = 3'd0;
                end
            end
            default: n_pop_s = 3'd0;
        endcase
    end

    // Pointer, occupancy and head PC sequencing; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            head_pc_r <= RESET_PC;
        end else if (flush) begin
            rd_ptr_r  <= wr_ptr_r;
            count_r   <= {CW{1'b0}};
            head_pc_r <= flush_pc;
        end else begin
            rd_ptr_r  <= rd_ptr_r + PW'(n_pop_s);
            wr_ptr_r  <= wr_ptr_r + PW'(push_n_eff_s);
            count_r   <= count_r + CW'(push_n_eff_s) - CW'(n_pop_s);
            head_pc_r <= head_pc_r + {28'd0, n_pop_s, 1'b0};
        end
    end

    // Halfword storage; leading halfwords ahead of in_pc[2:1] are never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_HW; i++) begin
                mem_r[i] <= {HW_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_en_s[k]) begin
                    mem_r[wr_idx_s[k]] <= in_data[16*k +: 16];
                end
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign count       = count_r;
    assign slot0_valid = s0_valid_s;
    assign slot0_instr = s0_instr_s;
    assign slot0_pc    = head_pc_r;
    assign slot0_is16  = s0_is16_s;
    assign slot1_valid = s1_valid_s;
    assign slot1_instr = s1_instr_s;
    assign slot1_pc    = head_pc_r + {29'd0, len0_s, 1'b0};
    assign slot1_is16  = s1_is16_s;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench: directed vector table, hand-written full/flush sequences,
// then random traffic compared against a halfword-queue reference model.
module tb_fetch_align_buffer;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOPI  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [31:0] in_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        slot0_valid;
    logic [31:0] slot0_instr;
    logic [31:0] slot0_pc;
    logic        slot0_is16;
    logic        slot1_valid;
    logic [31:0] slot1_instr;
    logic [31:0] slot1_pc;
    logic        slot1_is16;
    logic [1:0]  take;
    logic [4:0]  count;

    fetch_align_buffer #(.DEPTH_HW(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_pc       (in_pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .slot0_valid (slot0_valid),
        .slot0_instr (slot0_instr),
        .slot0_pc    (slot0_pc),
        .slot0_is16  (slot0_is16),
        .slot1_valid (slot1_valid),
        .slot1_instr (slot1_instr),
        .slot1_pc    (slot1_pc),
        .slot1_is16  (slot1_is16),
        .take        (take),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int proto_flags = 0;

    typedef struct {
        logic        r;
        logic        iv;
        logic [63:0] d;
        logic [31:0] pc;
        logic [1:0]  tk;
        logic        fl;
        logic [31:0] fpc;
        int          cnt;
        logic        v0;
        logic [31:0] i0;
        logic [31:0] p0;
        logic        s0;
        logic        v1;
        logic [31:0] i1;
        logic [31:0] p1;
        logic        s1;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: queued halfwords, oldest first, and the head address.
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        e_v0, e_s0, e_v1, e_s1;
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
    int          e_l0, e_l1;

    // Over-asking decode is a protocol error; count each occurrence the design must clamp.
    always @(posedge clk) begin
        if (rst_n && !flush && (int'(take) > int'(slot0_valid) + int'(slot1_valid))) begin
            proto_flags <= proto_flags + 1;
        end
    end

    function automatic vec_t V(logic r, logic iv, logic [63:0] d, logic [31:0] pc, logic [1:0] tk,
                               logic fl, logic [31:0] fpc, int cnt,
                               logic v0, logic [31:0] i0, logic [31:0] p0, logic s0,
                               logic v1, logic [31:0] i1, logic [31:0] p1, logic s1);
        vec_t v;
        v = '{r, iv, d, pc, tk, fl, fpc, cnt, v0, i0, p0, s0, v1, i1, p1, s1};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt,
                                 input logic v0, input logic [31:0] i0, input logic [31:0] p0, input logic s0,
                                 input logic v1, input logic [31:0] i1, input logic [31:0] p1, input logic s1);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'((DEPTH - cnt) >= 4));
        chk({tag, ".slot0_valid"}, 32'(slot0_valid), 32'(v0));
        chk({tag, ".slot0_instr"}, slot0_instr, v0 ? i0 : NOPI);
        chk({tag, ".slot0_is16"}, 32'(slot0_is16), 32'(v0 & s0));
        if (v0) chk({tag, ".slot0_pc"}, slot0_pc, p0);
        chk({tag, ".slot1_valid"}, 32'(slot1_valid), 32'(v1));
        chk({tag, ".slot1_instr"}, slot1_instr, v1 ? i1 : NOPI);
        chk({tag, ".slot1_is16"}, 32'(slot1_is16), 32'(v1 & s1));
        if (v1) chk({tag, ".slot1_pc"}, slot1_pc, p1);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [63:0] d, input logic [31:0] pc,
                         input logic [1:0] tk, input logic fl, input logic [31:0] fpc);
        rst_n = r; in_valid = iv; in_data = d; in_pc = pc; take = tk; flush = fl; flush_pc = fpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int mlen(input logic [15:0] h);
        return (h[1:0] == 2'b11) ? 2 : 1;
    endfunction

    // Decode slots straight from the model queue.
    task automatic model_slots();
        e_v0 = 1'b0; e_i0 = NOPI; e_p0 = mpc; e_s0 = 1'b0; e_l0 = 0;
        e_v1 = 1'b0; e_i1 = NOPI; e_p1 = mpc; e_s1 = 1'b0; e_l1 = 0;
        if (mq.size() >= 1) begin
            e_l0 = mlen(mq[0]);
            if (mq.size() >= e_l0) begin
                e_v0 = 1'b1;
                e_s0 = (e_l0 == 1);
                e_i0 = e_s0 ? {16'h0000, mq[0]} : {mq[1], mq[0]};
            end
        end
        if (e_v0 && mq.size() >= e_l0 + 1) begin
            e_l1 = mlen(mq[e_l0]);
            e_p1 = mpc + 32'(2 * e_l0);
            if (mq.size() >= e_l0 + e_l1) begin
                e_v1 = 1'b1;
                e_s1 = (e_l1 == 1);
                e_i1 = e_s1 ? {16'h0000, mq[e_l0]} : {mq[e_l0 + 1], mq[e_l0]};
            end
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int   nv, eff, npop;
        logic rdy;
        if (!rst_n) begin
            mq.delete();
            mpc = 32'h0000_0000;
        end else if (flush) begin
            mq.delete();
            mpc = flush_pc;
        end else begin
            model_slots();
            nv   = int'(e_v0) + int'(e_v1);
            eff  = (int'(take) > nv) ? nv : int'(take);
            npop = (eff == 0) ? 0 : (eff == 1) ? e_l0 : e_l0 + e_l1;
            rdy  = (DEPTH - mq.size()) >= 4;
            repeat (npop) void'(mq.pop_front());
            mpc = mpc + 32'(2 * npop);
            if (in_valid && rdy) begin
                for (int k = int'(in_pc[2:1]); k < 4; k++) mq.push_back(in_data[16*k +: 16]);
            end
        end
    endtask

    initial begin
        logic [15:0] h;
        logic [63:0] d;
        drive(1'b0, 1'b0, 64'h0, 32'h0, 2'd0, 1'b0, 32'h0);

        // Directed vectors: {inputs for one cycle, outputs expected after that edge}.
        vecs.push_back(V(0, 1, 64'h00000013_00000013, 32'h0,   2'd2, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h00000013_00000013, 32'h0,   2'd0, 0, 32'h0,   4, 1, 32'h13, 32'h0, 0, 1, 32'h13, 32'h4, 0));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(0, 0, 64'h0,                 32'h0,   2'd0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h57c157c1_57c157c1, 32'h0,   2'd0, 0, 32'h0,   4, 1, 32'h57c1, 32'h0, 1, 1, 32'h57c1, 32'h2, 1));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   2, 1, 32'h57c1, 32'h4, 1, 1, 32'h57c1, 32'h6, 1));
        vecs.push_back(V(0, 0, 64'h0,                 32'h0,   2'd0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h57c10000_001357c1, 32'h0,   2'd0, 0, 32'h0,   4, 1, 32'h57c1, 32'h0, 1, 1, 32'h13, 32'h2, 0));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   1, 1, 32'h57c1, 32'h6, 1, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h57c157c1_57c157c1, 32'h0,   2'd2, 1, 32'h106, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h0013_1111_2222_3333, 32'h106, 2'd0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'hAAAA_BBBB_CCCC_0000, 32'h108, 2'd0, 0, 32'h0, 5, 1, 32'h13, 32'h106, 0, 1, 32'h0000CCCC, 32'h10A, 1));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   2, 1, 32'hAAAABBBB, 32'h10C, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h00000013_00000013, 32'h110, 2'd0, 0, 32'h0,   4, 1, 32'h13, 32'h110, 0, 1, 32'h13, 32'h114, 0));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd3, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h0013_57c1_57c1_57c1, 32'h118, 2'd0, 0, 32'h0, 4, 1, 32'h57c1, 32'h118, 1, 1, 32'h57c1, 32'h11A, 1));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   2, 1, 32'h57c1, 32'h11C, 1, 0, 0, 0, 0));
        vecs.push_back(V(1, 0, 64'h0,                 32'h0,   2'd2, 0, 32'h0,   1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(V(1, 1, 64'h0,                 32'h120, 2'd0, 0, 32'h0,   5, 1, 32'h13, 32'h11E, 0, 1, 32'h0, 32'h122, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].pc, vecs[i].tk, vecs[i].fl, vecs[i].fpc);
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].v0, vecs[i].i0, vecs[i].p0, vecs[i].s0,
                          vecs[i].v1, vecs[i].i1, vecs[i].p1, vecs[i].s1);
        end

        // Fill to capacity, then check that in_ready ignores a same-cycle pop.
        drive(1'b0, 1'b0, 64'h0, 32'h0, 2'd0, 1'b0, 32'h0);
        step();
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 1'b1, 64'h00000013_00000013, 32'(8 * p), 2'd0, 1'b0, 32'h0);
            step();
            chk($sformatf("fill%0d.count", p), 32'(count), 32'(4 * (p + 1)));
        end
        chk("full.in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 1'b1, 64'h00000013_00000013, 32'h20, 2'd1, 1'b0, 32'h0);
        step();
        check_outputs("full_take1", 14, 1, 32'h13, 32'h4, 0, 1, 32'h13, 32'h8, 0);
        drive(1'b1, 1'b0, 64'h0, 32'h0, 2'd1, 1'b0, 32'h0);
        step();
        check_outputs("full_take2", 12, 1, 32'h13, 32'h8, 0, 1, 32'h13, 32'hC, 0);
        drive(1'b1, 1'b1, 64'h00000013_00000013, 32'h20, 2'd0, 1'b0, 32'h0);
        step();
        chk("refill.count", 32'(count), 32'd16);
        drive(1'b1, 1'b1, 64'h57c157c1_57c157c1, 32'h28, 2'd2, 1'b1, 32'h2000);
        step();
        check_outputs("flush_all", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b1, 64'h0000_0013_57c1_57c1, 32'h2000, 2'd0, 1'b0, 32'h0);
        step();
        check_outputs("post_flush", 4, 1, 32'h57c1, 32'h2000, 1, 1, 32'h57c1, 32'h2002, 1);

        // Random traffic against the reference model, starting from reset.
        mq.delete();
        mpc = 32'h0;
        for (int n = 0; n < 4000; n++) begin
            rst_n    = (n == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            flush_pc = $urandom & 32'hFFFF_FFFE;
            in_valid = ($urandom_range(0, 2) != 0);
            in_pc    = $urandom & 32'hFFFF_FFFE;
            for (int k = 0; k < 4; k++) begin
                h = 16'($urandom);
                if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
                d[16*k +: 16] = h;
            end
            in_data = d;
            model_slots();
            take = 2'($urandom_range(0, int'(e_v0) + int'(e_v1)));
            if ($urandom_range(0, 49) == 0) take = 2'($urandom_range(0, 3));
            model_step();
            step();
            model_slots();
            check_outputs($sformatf("rnd%0d", n), mq.size(), e_v0, e_i0, e_p0, e_s0, e_v1, e_i1, e_p1, e_s1);
        end

        $display("protocol monitor: %0d over-take events observed", proto_flags);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
